cdb_arbiter: RTL and testbench
==============================

# cdb_arbiter

Common Data Bus (CDB) arbiter for the out-of-order backend. Result producers (ALU reservation-station pipe, load/store unit, and any further functional units) compete for the single CDB write port each cycle. The block grants one requester per cycle round-robin and registers the winning tag/value onto the CDB. Reservation stations, the register status table and the ROB snoop the CDB.

## Interface
Parameters:
- NUM_REQ, 4, number of result producers (≥2); index 0 = load/store unit, 1 = ALU pipe.
- TAG_W, 4, reservation-station tag width; tag 0 is reserved ("no producer").
- DATA_W, `XLEN, result width.
- IDX_W, $clog2(NUM_REQ), source-index width.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  NUM_REQ  producer i has a result pending.
- req_tag  in  NUM_REQ*TAG_W  tag of producer i, slice [i*TAG_W +: TAG_W].
- req_data  in  NUM_REQ*DATA_W  result of producer i, slice [i*DATA_W +: DATA_W].
- req_ready  out  NUM_REQ  one-hot grant, combinational; producer i's result is accepted this cycle.
- cdb_stall  in  1  downstream (ROB full) blocks new grants this cycle.
- cdb_valid  out  1  registered broadcast valid.
- cdb_tag  out  TAG_W  registered broadcast tag.
- cdb_data  out  DATA_W  registered broadcast value.
- cdb_src  out  IDX_W  index of producer that owns the current broadcast.
- flush  in  1  present only with CDB_FLUSH_EN.

## Operation
- State: round-robin pointer rr_ptr (IDX_W bits, indexes NUM_REQ entries) plus output register {cdb_valid, cdb_tag, cdb_data, cdb_src}.
- Grant search: scan indices rr_ptr, rr_ptr+1, … modulo NUM_REQ; first i with req_valid[i]=1 and req_tag slice ≠ 0 wins. Requests with tag 0 are never granted (producer error; they remain pending).
- req_ready[winner]=1 only if cdb_stall=0; at most one bit set; all zero when no eligible requester or stalled.
- Handshake: producer holds valid/tag/data stable until req_ready seen high; transfer occurs on a clock edge with req_valid & req_ready. Producer may drop valid only after transfer.
- On transfer: output register loads {1, tag, data, i}; rr_ptr ← (i+1) mod NUM_REQ (wrap NUM_REQ-1 → 0, also for non-power-of-two NUM_REQ).
- No transfer (idle, stall): cdb_valid ← 0; cdb_tag/cdb_data/cdb_src hold previous values; rr_ptr unchanged.
- Each broadcast lasts exactly one cycle; no result is ever broadcast twice or dropped.
- Fairness: a continuously valid requester waits at most NUM_REQ-1 granted cycles.

## Timing
- Reset (rst_n low, asynchronous): cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_src=0, rr_ptr=0; req_ready=0 while rst_n low. Reset mid-stream discards the pending broadcast immediately.
- Latency: grant in cycle t → cdb_valid=1 with that result in cycle t+1.
- Throughput: one broadcast per cycle; back-to-back grants sustain cdb_valid=1 continuously.
- cdb_stall affects grants in the same cycle (combinational to req_ready); broadcast already registered still appears in the next cycle.
- Simultaneous requests: resolved solely by rr_ptr; no fixed priority.

## Configuration
- CDB_FLUSH_EN defined: flush port exists. flush=1 (branch mispredict recovery) forces req_ready=0 that cycle, clears cdb_valid to 0 next cycle (tag/data/src zeroed), resets rr_ptr to 0. flush has priority over any grant; cdb_stall ignored while flushing.
- CDB_FLUSH_EN undefined: no flush port; state cleared only by rst_n.

## Test plan
- Single request: req_valid[1]=1, tag 5, data 0xDEADBEEF at cycle t → req_ready=4'b0010 at t; cdb_valid=1, cdb_tag=5, cdb_data=0xDEADBEEF, cdb_src=1 at t+1; cdb_valid=0 at t+2.
- Full contention: all four valid continuously from reset, tags 1..4 → grant order 0,1,2,3,0,1…; cdb_valid stays 1; cdb_tag sequence 1,2,3,4 repeating.
- Pointer wrap: after grant to 1 (rr_ptr=2), requests on 0 and 3 → grant 3 first, then 0; rr_ptr ends at 1.
- Stall: req 2 pending, cdb_stall=1 for 3 cycles → req_ready=0, cdb_valid=0 throughout; stall drops → grant 2 that cycle, broadcast next cycle; tag-0 request on 0 never granted.
- Reset mid-stream: rst_n low asynchronously between edges while cdb_valid=1 → all outputs 0 immediately; after release, requester 0 wins first.
- With CDB_FLUSH_EN: flush=1 during full contention with rr_ptr=3 → req_ready=0, cdb_valid=0 next cycle, following grant goes to requester 0.

Source files
------------

// File: rtl/cdb_arbiter.sv
`default_nettype none
`ifndef XLEN
`define XLEN 32
`endif
// ============================================================================
// Module   : cdb_arbiter
// Brief    : Round-robin Common Data Bus arbiter with a registered broadcast.
//            Optional flush port when CDB_FLUSH_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module cdb_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 4,
  parameter int DATA_W  = `XLEN,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      cdb_stall,
`ifdef CDB_FLUSH_EN
  input  logic                      flush,
`endif
  output logic                      cdb_valid,
  output logic [TAG_W-1:0]          cdb_tag,
  output logic [DATA_W-1:0]         cdb_data,
  output logic [IDX_W-1:0]          cdb_src
);

  localparam logic [IDX_W-1:0] c_LAST = IDX_W'(NUM_REQ - 1);
  localparam logic [IDX_W:0]   c_NUM  = (IDX_W+1)'(NUM_REQ);

  logic [IDX_W-1:0]  r_rr_ptr;
  logic              r_cdb_valid;
  logic [TAG_W-1:0]  r_cdb_tag;
  logic [DATA_W-1:0] r_cdb_data;
  logic [IDX_W-1:0]  r_cdb_src;

  logic              w_flush;
  logic              w_found;
  logic              w_grant;
  logic [IDX_W-1:0]  w_win;
  logic [IDX_W:0]    w_idx;

`ifdef CDB_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  // Scan from the pointer with an extra bit so the modulo also works for non-power-of-two NUM_REQ.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = {1'b0, r_rr_ptr} + (IDX_W+1)'(k);
      if (w_idx >= c_NUM) begin
        w_idx = w_idx - c_NUM;
      end
      if (!w_found && req_valid[w_idx[IDX_W-1:0]] &&
          (req_tag[w_idx[IDX_W-1:0]*TAG_W +: TAG_W] != '0)) begin
        w_found = 1'b1;
        w_win   = w_idx[IDX_W-1:0];
      end
    end
  end

  assign w_grant   = w_found & ~cdb_stall & ~w_flush & rst_n;
  assign req_ready = w_grant ? (NUM_REQ'(1) << w_win) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr    <= '0;
      r_cdb_valid <= 1'b0;
      r_cdb_tag   <= '0;
      r_cdb_data  <= '0;
      r_cdb_src   <= '0;
    end else if (w_flush) begin
      r_rr_ptr    <= '0;
      r_cdb_valid <= 1'b0;
      r_cdb_tag   <= '0;
      r_cdb_data  <= '0;
      r_cdb_src   <= '0;
    end else if (w_grant) begin
      r_rr_ptr    <= (w_win == c_LAST) ? '0 : w_win + IDX_W'(1);
      r_cdb_valid <= 1'b1;
      r_cdb_tag   <= req_tag[w_win*TAG_W +: TAG_W];
      r_cdb_data  <= req_data[w_win*DATA_W +: DATA_W];
      r_cdb_src   <= w_win;
    end else begin
      r_cdb_valid <= 1'b0;
    end
  end

  assign cdb_valid = r_cdb_valid;
  assign cdb_tag   = r_cdb_tag;
  assign cdb_data  = r_cdb_data;
  assign cdb_src   = r_cdb_src;

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cdb_arbiter
// Brief    : Self-checking bench for cdb_arbiter using an expected-broadcast queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cdb_arbiter;

  localparam int N  = 4;
  localparam int TW = 4;
  localparam int DW = 32;
  localparam int IW = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req_valid;
  logic [N*TW-1:0]   req_tag;
  logic [N*DW-1:0]   req_data;
  logic [N-1:0]      req_ready;
  logic              cdb_stall;
  logic              cdb_valid;
  logic [TW-1:0]     cdb_tag;
  logic [DW-1:0]     cdb_data;
  logic [IW-1:0]     cdb_src;
`ifdef CDB_FLUSH_EN
  logic              flush = 1'b0;
`endif

  typedef struct packed {
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
    logic [IW-1:0] src;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   m_ptr    = 0;

  always #5 clk = ~clk;

  cdb_arbiter #(.NUM_REQ(N), .TAG_W(TW), .DATA_W(DW), .IDX_W(IW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_tag   (req_tag),
    .req_data  (req_data),
    .req_ready (req_ready),
    .cdb_stall (cdb_stall),
`ifdef CDB_FLUSH_EN
    .flush     (flush),
`endif
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_data  (cdb_data),
    .cdb_src   (cdb_src)
  );

  // Reference round-robin choice from the bench's own pointer model.
  function automatic int model_winner();
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (req_valid[i] && req_tag[i*TW +: TW] != '0) return i;
    end
    return -1;
  endfunction

  task automatic clear_inputs();
    req_valid = '0;
    req_tag   = '0;
    req_data  = '0;
    cdb_stall = 1'b0;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst_n = 1'b0;
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    m_ptr = 0;
    sb.delete();
  endtask

  task automatic set_all_valid();
    for (int i = 0; i < N; i++) begin
      req_tag[i*TW +: TW]  = TW'(i + 1);
      req_data[i*DW +: DW] = 32'hA000_0000 + 32'(i);
    end
    req_valid = '1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    req_valid = 4'b0001;
    req_tag   = 16'h0001;
    repeat (2) @(negedge clk);
    n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready got %b need 0000", req_ready); end
    n_checks++; if (cdb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b need 0", cdb_valid); end
    n_checks++; if (cdb_tag !== '0) begin n_fail++; $display("FAIL reset_tag got %h need 0", cdb_tag); end
    n_checks++; if (cdb_data !== '0) begin n_fail++; $display("FAIL reset_data got %h need 0", cdb_data); end
    n_checks++; if (cdb_src !== '0) begin n_fail++; $display("FAIL reset_src got %0d need 0", cdb_src); end
    clear_inputs();
    rst_n = 1'b1;
    m_ptr = 0;
  endtask

  task automatic test_single();
    @(negedge clk);
    req_valid = 4'b0010;
    req_tag[1*TW +: TW]  = 4'd5;
    req_data[1*DW +: DW] = 32'hDEAD_BEEF;
    #1;
    n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL single_ready got %b need 0010", req_ready); end
    @(posedge clk); @(negedge clk);
    req_valid = '0;
    n_checks++;
    if ({cdb_valid, cdb_tag, cdb_data, cdb_src} !== {1'b1, 4'd5, 32'hDEAD_BEEF, 2'd1}) begin
      n_fail++;
      $display("FAIL single_bcast got v=%b tag=%h data=%h src=%0d need v=1 tag=5 data=deadbeef src=1",
               cdb_valid, cdb_tag, cdb_data, cdb_src);
    end
    @(posedge clk); @(negedge clk);
    n_checks++; if (cdb_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_drop got %b need 0", cdb_valid); end
    n_checks++; if (cdb_tag !== 4'd5) begin n_fail++; $display("FAIL single_tag_hold got %h need 5", cdb_tag); end
    m_ptr = 2;
  endtask

  task automatic test_contention();
    int w; logic [N-1:0] exp_rdy; exp_t e;
    reset_dut();
    set_all_valid();
    for (int c = 0; c < 8; c++) begin
      #1;
      w = model_winner();
      exp_rdy = (w >= 0 && !cdb_stall) ? (N'(1) << w) : '0;
      n_checks++; if (req_ready !== exp_rdy) begin n_fail++; $display("FAIL contention_ready c%0d got %b need %b", c, req_ready, exp_rdy); end
      if (exp_rdy != '0) begin
        e.tag = req_tag[w*TW +: TW]; e.data = req_data[w*DW +: DW]; e.src = IW'(w);
        sb.push_back(e); m_ptr = (w + 1) % N;
      end
      @(posedge clk); @(negedge clk);
      n_checks++; if (cdb_valid !== 1'b1) begin n_fail++; $display("FAIL contention_valid c%0d got %b need 1", c, cdb_valid); end
      n_checks++; if (cdb_tag !== TW'((c % 4) + 1)) begin n_fail++; $display("FAIL contention_tag_seq c%0d got %0d need %0d", c, cdb_tag, (c % 4) + 1); end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        n_checks++;
        if ({cdb_tag, cdb_data, cdb_src} !== {e.tag, e.data, e.src}) begin
          n_fail++; $display("FAIL contention_bcast c%0d got %h/%h/%0d need %h/%h/%0d", c, cdb_tag, cdb_data, cdb_src, e.tag, e.data, e.src);
        end
      end
    end
    clear_inputs();
  endtask

  task automatic test_wrap();
    int w; logic [N-1:0] exp_rdy; exp_t e;
    int exp_src[3] = '{1, 3, 0};
    reset_dut();
    req_valid = 4'b0010;
    req_tag   = 16'h0060;
    req_data[1*DW +: DW] = 32'h1111_0001;
    for (int c = 0; c < 3; c++) begin
      #1;
      w = model_winner();
      exp_rdy = (w >= 0 && !cdb_stall) ? (N'(1) << w) : '0;
      n_checks++; if (req_ready !== exp_rdy) begin n_fail++; $display("FAIL wrap_ready c%0d got %b need %b", c, req_ready, exp_rdy); end
      if (exp_rdy != '0) begin
        e.tag = req_tag[w*TW +: TW]; e.data = req_data[w*DW +: DW]; e.src = IW'(w);
        sb.push_back(e); m_ptr = (w + 1) % N;
      end
      @(posedge clk); @(negedge clk);
      if (w >= 0) req_valid[w] = 1'b0;
      if (c == 0) begin
        req_valid[0] = 1'b1; req_tag[0*TW +: TW] = 4'd2; req_data[0*DW +: DW] = 32'h2222_0000;
        req_valid[3] = 1'b1; req_tag[3*TW +: TW] = 4'd9; req_data[3*DW +: DW] = 32'h2222_0003;
      end
      n_checks++; if (cdb_src !== IW'(exp_src[c]) || cdb_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_order c%0d got src=%0d v=%b need src=%0d v=1", c, cdb_src, cdb_valid, exp_src[c]); end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        n_checks++;
        if ({cdb_tag, cdb_data, cdb_src} !== {e.tag, e.data, e.src}) begin
          n_fail++; $display("FAIL wrap_bcast c%0d got %h/%h/%0d need %h/%h/%0d", c, cdb_tag, cdb_data, cdb_src, e.tag, e.data, e.src);
        end
      end
    end
    // Pointer should now sit at 1: requests on 1 and 2 pick 1.
    req_valid = 4'b0110; req_tag = 16'h0330;
    #1;
    n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL wrap_ptr_end got %b need 0010", req_ready); end
    clear_inputs();
  endtask

  task automatic test_stall();
    int w; logic [N-1:0] exp_rdy; exp_t e;
    reset_dut();
    req_valid = 4'b0101;
    req_tag   = 16'h0700;
    req_data[2*DW +: DW] = 32'h3333_0002;
    req_data[0*DW +: DW] = 32'h3333_0000;
    cdb_stall = 1'b1;
    for (int c = 0; c < 7; c++) begin
      if (c == 3) cdb_stall = 1'b0;
      #1;
      w = model_winner();
      exp_rdy = (w >= 0 && !cdb_stall) ? (N'(1) << w) : '0;
      n_checks++; if (req_ready !== exp_rdy) begin n_fail++; $display("FAIL stall_ready c%0d got %b need %b", c, req_ready, exp_rdy); end
      n_checks++; if (req_ready[0] !== 1'b0) begin n_fail++; $display("FAIL stall_tag0_grant c%0d got %b need 0", c, req_ready[0]); end
      if (exp_rdy != '0) begin
        e.tag = req_tag[w*TW +: TW]; e.data = req_data[w*DW +: DW]; e.src = IW'(w);
        sb.push_back(e); m_ptr = (w + 1) % N;
      end
      @(posedge clk); @(negedge clk);
      if (exp_rdy != '0) req_valid[w] = 1'b0;
      n_checks++; if (cdb_valid !== (sb.size() != 0)) begin n_fail++; $display("FAIL stall_valid c%0d got %b need %b", c, cdb_valid, sb.size() != 0); end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        n_checks++;
        if ({cdb_tag, cdb_data, cdb_src} !== {e.tag, e.data, e.src} || c != 3) begin
          n_fail++; $display("FAIL stall_bcast c%0d got %h/%h/%0d need %h/%h/%0d at c3", c, cdb_tag, cdb_data, cdb_src, e.tag, e.data, e.src);
        end
      end
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    int w; logic [N-1:0] exp_rdy; exp_t e;
    reset_dut();
    set_all_valid();
    @(posedge clk); @(negedge clk);
    n_checks++; if (cdb_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre_valid got %b need 1", cdb_valid); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({cdb_valid, cdb_tag, cdb_data, cdb_src, req_ready} !== '0) begin
      n_fail++; $display("FAIL rstmid_clear got v=%b tag=%h data=%h src=%0d rdy=%b need all 0", cdb_valid, cdb_tag, cdb_data, cdb_src, req_ready);
    end
    @(negedge clk);
    rst_n = 1'b1; m_ptr = 0; sb.delete();
    for (int c = 0; c < 4; c++) begin
      #1;
      w = model_winner();
      exp_rdy = (w >= 0 && !cdb_stall) ? (N'(1) << w) : '0;
      n_checks++; if (req_ready !== exp_rdy) begin n_fail++; $display("FAIL rstmid_ready c%0d got %b need %b", c, req_ready, exp_rdy); end
      if (c == 0) begin
        n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL rstmid_first_grant got %b need 0001", req_ready); end
      end
      if (exp_rdy != '0) begin
        e.tag = req_tag[w*TW +: TW]; e.data = req_data[w*DW +: DW]; e.src = IW'(w);
        sb.push_back(e); m_ptr = (w + 1) % N;
      end
      @(posedge clk); @(negedge clk);
      n_checks++; if (cdb_valid !== (sb.size() != 0)) begin n_fail++; $display("FAIL rstmid_valid c%0d got %b need %b", c, cdb_valid, sb.size() != 0); end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        n_checks++;
        if ({cdb_tag, cdb_data, cdb_src} !== {e.tag, e.data, e.src}) begin
          n_fail++; $display("FAIL rstmid_bcast c%0d got %h/%h/%0d need %h/%h/%0d", c, cdb_tag, cdb_data, cdb_src, e.tag, e.data, e.src);
        end
      end
    end
    clear_inputs();
  endtask

`ifdef CDB_FLUSH_EN
  task automatic test_flush();
    reset_dut();
    set_all_valid();
    repeat (3) @(negedge clk);
    n_checks++; if (cdb_src !== 2'd2 || cdb_valid !== 1'b1) begin n_fail++; $display("FAIL flush_pre got src=%0d v=%b need src=2 v=1", cdb_src, cdb_valid); end
    flush = 1'b1;
    cdb_stall = 1'b1;
    #1;
    n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL flush_ready got %b need 0000", req_ready); end
    @(posedge clk); @(negedge clk);
    flush = 1'b0;
    cdb_stall = 1'b0;
    n_checks++;
    if ({cdb_valid, cdb_tag, cdb_data, cdb_src} !== '0) begin
      n_fail++; $display("FAIL flush_clear got v=%b tag=%h data=%h src=%0d need all 0", cdb_valid, cdb_tag, cdb_data, cdb_src);
    end
    #1;
    n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL flush_next_grant got %b need 0001", req_ready); end
    clear_inputs();
    m_ptr = 0;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_wrap();
    test_stall();
    test_reset_mid();
`ifdef CDB_FLUSH_EN
    test_flush();
`endif
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
